sd_spi_master: RTL and testbench

Parametrised SPI master serving as the next-generation transport engine for the SD card peripheral. It adds the following over the previous fixed SD SPI engine:
- configurable word width;
- runtime clock divisor, covering the <400 kHz SD init rate and fast data rate;
- all four SPI modes;
- multiple chip selects, with an optional CS-hold so multi-byte SD commands and blocks run under one CS assertion.

It sits between the SoC register interface and the SD card pins, with a Start/Busy/Done handshake toward the register side.

---
 rtl/sd_spi_master_if.sv | 32 +++
 rtl/sd_spi_master.sv | 152 +++++++++++++++
 tb/tb_sd_spi_master.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_spi_master_if.sv
// Register-side bundle of the SD SPI master: transfer request, latched
// configuration, and the Busy/Done/RxData status returned to the SoC.
interface sd_spi_master_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CS     = 2,
  parameter int DIV_WIDTH  = 8
);
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic                  Start;
  logic [DATA_WIDTH-1:0] TxData;
  logic [DIV_WIDTH-1:0]  ClkDiv;
  logic                  CPOL;
  logic                  CPHA;
  logic                  LsbFirst;
  logic [CS_W-1:0]       CsSelect;
  logic                  CsHold;
  logic                  CsRelease;
  logic                  Busy;
  logic                  Done;
  logic [DATA_WIDTH-1:0] RxData;

  modport master (
    output Start, TxData, ClkDiv, CPOL, CPHA, LsbFirst, CsSelect, CsHold, CsRelease,
    input  Busy, Done, RxData
  );

  modport slave (
    input  Start, TxData, ClkDiv, CPOL, CPHA, LsbFirst, CsSelect, CsHold, CsRelease,
    output Busy, Done, RxData
  );
endinterface

// File: rtl/sd_spi_master.sv
// SPI master for the SD card path: configurable word width, runtime SCLK
// divisor, all four SPI modes and multiple chip selects with optional CS hold.
module sd_spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CS     = 2,
  parameter int DIV_WIDTH  = 8
) (
  input  logic              MasterCLK,
  input  logic              Reset,
  sd_spi_master_if.slave    regIf,
  output logic              SPI_SCLK,
  output logic              SPI_MOSI,
  input  logic              SPI_MISO,
  output logic [NUM_CS-1:0] SPI_CS_N
);

  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int HALF_W = $clog2(2 * DATA_WIDTH);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} stateT;

  stateT                 state;
  stateT                 stateNext;
  logic [DIV_WIDTH-1:0]  divCnt;
  logic [DIV_WIDTH-1:0]  divLat;
  logic [HALF_W-1:0]     halfCnt;
  logic                  cphaLat;
  logic                  lsbLat;
  logic                  csHoldLat;
  logic [DATA_WIDTH-1:0] txShift;
  logic [DATA_WIDTH-1:0] rxShift;
  logic [DATA_WIDTH-1:0] rxData;
  logic                  done;
  logic                  sclk;
  logic                  mosi;
  logic [NUM_CS-1:0]     csN;
  logic                  phaseEnd;
  logic                  lastHalf;
  logic                  leadEdge;
  logic                  trailEdge;
  logic                  sampleNow;
  logic                  shiftNow;

  // An out-of-range select simply matches no output, so every CS stays high.
  function automatic logic [NUM_CS-1:0] csMask(input logic [CS_W-1:0] sel);
    csMask = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(sel) == i) csMask[i] = 1'b0;
    end
  endfunction

  always_ff @(posedge MasterCLK) begin
    if (!Reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    phaseEnd  = (divCnt == divLat);
    lastHalf  = (halfCnt == HALF_LAST);
    case (state)
      IDLE:    if (regIf.Start) stateNext = SETUP;
      SETUP:   if (phaseEnd) stateNext = XFER;
      XFER:    if (phaseEnd && lastHalf) stateNext = HOLD;
      HOLD:    if (phaseEnd) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    leadEdge  = (state == XFER) && phaseEnd && !halfCnt[0];
    trailEdge = (state == XFER) && phaseEnd && halfCnt[0];
    // CPHA=0 already put bit 0 out in SETUP, so the final trailing edge has nothing left to shift.
    sampleNow = cphaLat ? trailEdge : leadEdge;
    shiftNow  = cphaLat ? leadEdge : (trailEdge && !lastHalf);
  end

  always_ff @(posedge MasterCLK) begin
    if (!Reset) begin
      divCnt    <= '0;
      divLat    <= '0;
      halfCnt   <= '0;
      cphaLat   <= 1'b0;
      lsbLat    <= 1'b0;
      csHoldLat <= 1'b0;
      txShift   <= '0;
      rxShift   <= '0;
      rxData    <= '0;
      done      <= 1'b0;
      sclk      <= 1'b0;
      mosi      <= 1'b1;
      csN       <= '1;
    end else begin
      done <= 1'b0;
      if (state == IDLE || phaseEnd) divCnt <= '0;
      else                           divCnt <= divCnt + 1'b1;

      if (sampleNow) begin
        rxShift <= lsbLat ? {SPI_MISO, rxShift[DATA_WIDTH-1:1]}
                          : {rxShift[DATA_WIDTH-2:0], SPI_MISO};
      end
      if (shiftNow) begin
        mosi    <= lsbLat ? txShift[0] : txShift[DATA_WIDTH-1];
        txShift <= lsbLat ? (txShift >> 1) : (txShift << 1);
      end

      case (state)
        IDLE: begin
          sclk <= regIf.CPOL;
          mosi <= 1'b1;
          if (regIf.Start) begin
            divLat    <= regIf.ClkDiv;
            cphaLat   <= regIf.CPHA;
            lsbLat    <= regIf.LsbFirst;
            csHoldLat <= regIf.CsHold;
            halfCnt   <= '0;
            csN       <= csMask(regIf.CsSelect);
            if (!regIf.CPHA) begin
              mosi    <= regIf.LsbFirst ? regIf.TxData[0] : regIf.TxData[DATA_WIDTH-1];
              txShift <= regIf.LsbFirst ? (regIf.TxData >> 1) : (regIf.TxData << 1);
            end else begin
              txShift <= regIf.TxData;
            end
          end else if (regIf.CsRelease) begin
            csN <= '1;
          end
        end
        XFER: begin
          if (phaseEnd) begin
            sclk    <= ~sclk;
            halfCnt <= halfCnt + 1'b1;
          end
        end
        HOLD: begin
          if (phaseEnd) begin
            done   <= 1'b1;
            rxData <= rxShift;
            mosi   <= 1'b1;
            if (!csHoldLat) csN <= '1;
          end
        end
        default: ;
      endcase
    end
  end

  assign regIf.Busy   = (state != IDLE);
  assign regIf.Done   = done;
  assign regIf.RxData = rxData;
  assign SPI_SCLK     = sclk;
  assign SPI_MOSI     = mosi;
  assign SPI_CS_N     = csN;

endmodule

// File: tb/tb_sd_spi_master.sv
// Self-checking bench for sd_spi_master: directed scenarios plus randomized
// transfers compared against a phase-arithmetic model of the SPI waveform.
module tb_sd_spi_master;
  localparam int DW   = 8;
  localparam int NCS  = 2;
  localparam int DIVW = 8;
  localparam int MAXT = 600;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  sd_spi_master_if #(.DATA_WIDTH(DW), .NUM_CS(NCS), .DIV_WIDTH(DIVW)) ifc ();
  sd_spi_master_if #(.DATA_WIDTH(DW), .NUM_CS(3), .DIV_WIDTH(DIVW)) ifc3 ();

  logic           sclk, mosi, miso, misoDrv, loopMode;
  logic [NCS-1:0] csN;
  logic           sclk3, mosi3;
  logic [2:0]     csN3;

  assign miso = loopMode ? mosi : misoDrv;

  sd_spi_master #(.DATA_WIDTH(DW), .NUM_CS(NCS), .DIV_WIDTH(DIVW)) dut (
    .MasterCLK(clk), .Reset(rstN), .regIf(ifc),
    .SPI_SCLK(sclk), .SPI_MOSI(mosi), .SPI_MISO(miso), .SPI_CS_N(csN)
  );

  sd_spi_master #(.DATA_WIDTH(DW), .NUM_CS(3), .DIV_WIDTH(DIVW)) dut3 (
    .MasterCLK(clk), .Reset(rstN), .regIf(ifc3),
    .SPI_SCLK(sclk3), .SPI_MOSI(mosi3), .SPI_MISO(misoDrv), .SPI_CS_N(csN3)
  );

  int checks = 0;
  int errors = 0;

  int   cfgDiv;
  logic cfgCpol, cfgCpha, cfgLsb;

  logic           trSclk [MAXT];
  logic           trMosi [MAXT];
  logic           trBusy [MAXT];
  logic [NCS-1:0] trCs   [MAXT];
  int             doneAt;
  logic [DW-1:0]  rxAtDone;

  // Model: the cycle after edge t lies in phase (t-1)/(ClkDiv+1); phase 0 is SETUP,
  // phases 1..2W are the SCLK half-periods, each ending in one SCLK toggle.
  function automatic int expDoneAt();
    return 1 + (2 * DW + 2) * (cfgDiv + 1);
  endfunction

  function automatic int togglesAt(input int t);
    int p;
    p = (t - 1) / (cfgDiv + 1);
    if (p < 1) return 0;
    if (p - 1 > 2 * DW) return 2 * DW;
    return p - 1;
  endfunction

  function automatic int bitIdx(input int t);
    int p, k;
    p = (t - 1) / (cfgDiv + 1);
    k = togglesAt(t);
    if (p > 2 * DW) return -1;
    if (!cfgCpha) return k / 2;
    if (k == 0) return -1;
    return (k - 1) / 2;
  endfunction

  function automatic logic wordBit(input logic [DW-1:0] w, input int i);
    return cfgLsb ? w[i] : w[DW-1-i];
  endfunction

  function automatic logic [NCS-1:0] expMask(input int sel);
    logic [NCS-1:0] m;
    m = '1;
    if (sel < NCS) m[sel] = 1'b0;
    return m;
  endfunction

  // Starts a transfer at a negedge and records the pins after every edge until Done.
  task automatic runXfer(input logic [DW-1:0] tx, input int div, input logic cpol,
                         input logic cpha, input logic lsb, input int sel, input logic hold,
                         input logic loop, input logic [DW-1:0] rxw, input logic disturb);
    int idx;
    cfgDiv = div; cfgCpol = cpol; cfgCpha = cpha; cfgLsb = lsb;
    loopMode = loop;
    ifc.TxData = tx; ifc.ClkDiv = DIVW'(div); ifc.CPOL = cpol; ifc.CPHA = cpha;
    ifc.LsbFirst = lsb; ifc.CsSelect = 1'(sel); ifc.CsHold = hold; ifc.CsRelease = 1'b0;
    ifc.Start = 1'b1;
    doneAt = -1;
    for (int t = 1; t < MAXT; t++) begin
      @(posedge clk);
      @(negedge clk);
      if (t == 1) ifc.Start = 1'b0;
      if (disturb && t == 3) begin
        ifc.Start = 1'b1; ifc.TxData = ~tx; ifc.ClkDiv = DIVW'(div + 2);
        ifc.CPHA = ~cpha; ifc.LsbFirst = ~lsb;
      end
      if (disturb && t == 4) ifc.Start = 1'b0;
      trSclk[t] = sclk; trMosi[t] = mosi; trBusy[t] = ifc.Busy; trCs[t] = csN;
      idx = bitIdx(t);
      misoDrv = (idx >= 0) ? wordBit(rxw, idx) : 1'($urandom);
      if (ifc.Done) begin
        doneAt = t;
        rxAtDone = ifc.RxData;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rstN = 1'b0;
    ifc.CPOL = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ifc.Busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", ifc.Busy); end
    checks++; if (ifc.Done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", ifc.Done); end
    checks++; if (ifc.RxData !== 8'h00) begin errors++; $display("[TB] FAIL reset_rx got %h want 00", ifc.RxData); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("[TB] FAIL reset_sclk got %b want 0", sclk); end
    checks++; if (mosi !== 1'b1) begin errors++; $display("[TB] FAIL reset_mosi got %b want 1", mosi); end
    checks++; if (csN !== 2'b11) begin errors++; $display("[TB] FAIL reset_cs got %b want 11", csN); end
    rstN = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (sclk !== 1'b1) begin errors++; $display("[TB] FAIL idle_cpol1 got %b want 1", sclk); end
    ifc.CPOL = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (sclk !== 1'b0) begin errors++; $display("[TB] FAIL idle_cpol0 got %b want 0", sclk); end
  endtask

  task automatic test_mode0_loop;
    logic [7:0] pat;
    pat = 8'hA5;
    runXfer(pat, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 8'h00, 1'b0);
    checks++; if (doneAt !== 19) begin errors++; $display("[TB] FAIL m0_done_cycle got %0d want 19", doneAt); end
    checks++; if (rxAtDone !== 8'hA5) begin errors++; $display("[TB] FAIL m0_rx got %h want a5", rxAtDone); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (trMosi[2 + 2*i] !== pat[7-i]) begin
        errors++; $display("[TB] FAIL m0_mosi bit%0d got %b want %b", i, trMosi[2 + 2*i], pat[7-i]);
      end
    end
    for (int t = 1; t <= 19; t++) begin
      checks++;
      if (trCs[t] !== ((t <= 18) ? 2'b10 : 2'b11)) begin
        errors++; $display("[TB] FAIL m0_cs t=%0d got %b", t, trCs[t]);
      end
    end
  endtask

  task automatic test_mode3_lsb;
    runXfer(8'h01, 3, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 8'hFF, 1'b0);
    checks++; if (doneAt !== 73) begin errors++; $display("[TB] FAIL m3_done_cycle got %0d want 73", doneAt); end
    checks++; if (rxAtDone !== 8'hFF) begin errors++; $display("[TB] FAIL m3_rx got %h want ff", rxAtDone); end
    checks++; if (trSclk[1] !== 1'b1 || trSclk[8] !== 1'b1) begin errors++; $display("[TB] FAIL m3_sclk_idle got %b%b want 11", trSclk[1], trSclk[8]); end
    checks++; if (trSclk[9] !== 1'b0 || trSclk[12] !== 1'b0) begin errors++; $display("[TB] FAIL m3_sclk_low got %b%b want 00", trSclk[9], trSclk[12]); end
    checks++; if (trSclk[13] !== 1'b1) begin errors++; $display("[TB] FAIL m3_sclk_high got %b want 1", trSclk[13]); end
    checks++; if (trMosi[9] !== 1'b1) begin errors++; $display("[TB] FAIL m3_mosi_first got %b want 1", trMosi[9]); end
    checks++; if (trMosi[17] !== 1'b0) begin errors++; $display("[TB] FAIL m3_mosi_second got %b want 0", trMosi[17]); end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] tx;
    for (int w = 0; w < 3; w++) begin
      tx = 8'($urandom);
      runXfer(tx, 0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 8'h00, 1'b0);
      checks++; if (doneAt !== 19) begin errors++; $display("[TB] FAIL b2b_done w=%0d got %0d want 19", w, doneAt); end
      checks++; if (rxAtDone !== tx) begin errors++; $display("[TB] FAIL b2b_rx w=%0d got %h want %h", w, rxAtDone, tx); end
      for (int t = 1; t <= doneAt; t++) begin
        checks++;
        if (trCs[t] !== 2'b01) begin errors++; $display("[TB] FAIL b2b_cs w=%0d t=%0d got %b want 01", w, t, trCs[t]); end
      end
    end
    ifc.CsRelease = 1'b1;
    @(posedge clk); @(negedge clk);
    ifc.CsRelease = 1'b0;
    checks++; if (csN !== 2'b11) begin errors++; $display("[TB] FAIL cs_release got %b want 11", csN); end
  endtask

  task automatic test_busy_ignore;
    logic [DW-1:0] tx;
    int extra;
    tx = 8'($urandom) | 8'h80;
    runXfer(tx, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 8'h00, 1'b1);
    checks++; if (doneAt !== 37) begin errors++; $display("[TB] FAIL ign_done got %0d want 37", doneAt); end
    checks++; if (rxAtDone !== tx) begin errors++; $display("[TB] FAIL ign_rx got %h want %h", rxAtDone, tx); end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
      if (ifc.Done || ifc.Busy) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL ign_queued got %0d busy/done cycles want 0", extra); end
  endtask

  task automatic test_reset_mid;
    int sawDone;
    loopMode = 1'b1;
    ifc.TxData = 8'($urandom); ifc.ClkDiv = '0; ifc.CPOL = 1'b1; ifc.CPHA = 1'b0;
    ifc.LsbFirst = 1'b0; ifc.CsSelect = 1'b0; ifc.CsHold = 1'b1; ifc.CsRelease = 1'b0;
    ifc.Start = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      @(posedge clk); @(negedge clk);
      if (t == 1) ifc.Start = 1'b0;
    end
    rstN = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (sclk !== 1'b0) begin errors++; $display("[TB] FAIL rmid_sclk got %b want 0", sclk); end
    checks++; if (mosi !== 1'b1) begin errors++; $display("[TB] FAIL rmid_mosi got %b want 1", mosi); end
    checks++; if (csN !== 2'b11) begin errors++; $display("[TB] FAIL rmid_cs got %b want 11", csN); end
    checks++; if (ifc.Busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy got %b want 0", ifc.Busy); end
    checks++; if (ifc.RxData !== 8'h00) begin errors++; $display("[TB] FAIL rmid_rx got %h want 00", ifc.RxData); end
    rstN = 1'b1;
    ifc.CPOL = 1'b0;
    sawDone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); @(negedge clk);
      if (ifc.Done) sawDone++;
    end
    checks++; if (sawDone !== 0) begin errors++; $display("[TB] FAIL rmid_done got %0d pulses want 0", sawDone); end
  endtask

  task automatic test_cs_out_of_range;
    int done3;
    ifc3.TxData = 8'($urandom); ifc3.ClkDiv = '0; ifc3.CPOL = 1'b0; ifc3.CPHA = 1'b0;
    ifc3.LsbFirst = 1'b0; ifc3.CsSelect = 2'd3; ifc3.CsHold = 1'b0; ifc3.CsRelease = 1'b0;
    ifc3.Start = 1'b1;
    done3 = -1;
    for (int t = 1; t < 60; t++) begin
      @(posedge clk); @(negedge clk);
      if (t == 1) ifc3.Start = 1'b0;
      checks++;
      if (csN3 !== 3'b111) begin errors++; $display("[TB] FAIL oor_cs t=%0d got %b want 111", t, csN3); end
      if (ifc3.Done) begin
        done3 = t;
        break;
      end
    end
    checks++; if (done3 !== 19) begin errors++; $display("[TB] FAIL oor_done got %0d want 19", done3); end
  endtask

  task automatic test_random_modes;
    logic [DW-1:0]  tx, rxw;
    logic [NCS-1:0] expCs;
    logic           hold, expSclk;
    int             div, sel, k, idx;
    for (int n = 0; n < 12; n++) begin
      tx = 8'($urandom); rxw = 8'($urandom);
      div = $urandom_range(0, 3); sel = $urandom_range(0, 1); hold = 1'($urandom);
      runXfer(tx, div, 1'(n >> 1), 1'(n), 1'($urandom), sel, hold, 1'b0, rxw, 1'b0);
      checks++;
      if (doneAt !== expDoneAt()) begin errors++; $display("[TB] FAIL rnd_done n=%0d got %0d want %0d", n, doneAt, expDoneAt()); end
      checks++;
      if (rxAtDone !== rxw) begin errors++; $display("[TB] FAIL rnd_rx n=%0d got %h want %h", n, rxAtDone, rxw); end
      for (int t = 1; t <= doneAt; t++) begin
        k = togglesAt(t);
        idx = bitIdx(t);
        expSclk = cfgCpol ^ k[0];
        expCs = (t == doneAt && !hold) ? 2'b11 : expMask(sel);
        checks++;
        if (trSclk[t] !== expSclk) begin errors++; $display("[TB] FAIL rnd_sclk n=%0d t=%0d got %b want %b", n, t, trSclk[t], expSclk); end
        checks++;
        if (trCs[t] !== expCs) begin errors++; $display("[TB] FAIL rnd_cs n=%0d t=%0d got %b want %b", n, t, trCs[t], expCs); end
        checks++;
        if (trBusy[t] !== 1'(t != doneAt)) begin errors++; $display("[TB] FAIL rnd_busy n=%0d t=%0d got %b", n, t, trBusy[t]); end
        if (idx >= 0) begin
          checks++;
          if (trMosi[t] !== wordBit(tx, idx)) begin errors++; $display("[TB] FAIL rnd_mosi n=%0d t=%0d got %b want %b", n, t, trMosi[t], wordBit(tx, idx)); end
        end
      end
    end
  endtask

  initial begin
    ifc.Start = 1'b0; ifc.TxData = '0; ifc.ClkDiv = '0; ifc.CPOL = 1'b0; ifc.CPHA = 1'b0;
    ifc.LsbFirst = 1'b0; ifc.CsSelect = '0; ifc.CsHold = 1'b0; ifc.CsRelease = 1'b0;
    ifc3.Start = 1'b0; ifc3.TxData = '0; ifc3.ClkDiv = '0; ifc3.CPOL = 1'b0; ifc3.CPHA = 1'b0;
    ifc3.LsbFirst = 1'b0; ifc3.CsSelect = '0; ifc3.CsHold = 1'b0; ifc3.CsRelease = 1'b0;
    misoDrv = 1'b0; loopMode = 1'b0;
    cfgDiv = 0; cfgCpol = 1'b0; cfgCpha = 1'b0; cfgLsb = 1'b0;
    @(negedge clk);
    test_reset();
    test_mode0_loop();
    test_mode3_lsb();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_cs_out_of_range();
    test_random_modes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
